// File: rtl/gomoku_pkg.sv
// Shared board constants, status encodings and controller state type
// for the gomoku move sequencing logic.
package gomoku_pkg;

   localparam int BOARD_N = 15;
   localparam int WIN_LEN = 5;
   localparam int COORD_W = 4;
   localparam int WIN_W   = 9;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_ILLEGAL = 2'd1;
   localparam logic [1:0] ST_WIN     = 2'd2;
   localparam logic [1:0] ST_DRAW    = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_WRITE,
      S_SETTLE,
      S_EVAL,
      S_CLEAR
   } state_t;

endpackage

// File: rtl/move_commit_ctrl_if.sv
// Move request / status response channel between game logic (master)
// and the move commit controller (slave).
interface move_commit_ctrl_if;
   import gomoku_pkg::*;

   logic               req_valid;
   logic               req_ready;
   logic [COORD_W-1:0] req_y;
   logic [COORD_W-1:0] req_x;
   logic               req_color;
   logic               clr_req;
   logic               rsp_valid;
   logic [1:0]         rsp_status;

   modport master (
      output req_valid, req_y, req_x, req_color, clr_req,
      input  req_ready, rsp_valid, rsp_status
   );

   modport slave (
      input  req_valid, req_y, req_x, req_color, clr_req,
      output req_ready, rsp_valid, rsp_status
   );

endinterface

// File: rtl/line_run_detect.sv
// Flags a run of WIN_LEN consecutive ones anywhere inside one line window.
module line_run_detect #(
   parameter int WIN_LEN = gomoku_pkg::WIN_LEN
) (
   input  logic [gomoku_pkg::WIN_W-1:0] window,
   output logic                         found
);

   localparam int N_POS = gomoku_pkg::WIN_W - WIN_LEN + 1;

   logic [N_POS-1:0] hit;

   for (genvar i = 0; i < N_POS; i++) begin : g_pos
      assign hit[i] = &window[i +: WIN_LEN];
   end

   assign found = |hit;

endmodule

// File: rtl/move_commit_ctrl.sv
// Move sequencer: occupancy check, board write, window evaluation and
// single status response; also owns board clear and the move counter.
module move_commit_ctrl
   import gomoku_pkg::*;
#(
   parameter int BOARD_N = gomoku_pkg::BOARD_N,
   parameter int WIN_LEN = gomoku_pkg::WIN_LEN
) (
   input  logic                clk,
   input  logic                rst,
   move_commit_ctrl_if.slave   bus,
   output logic                game_over,
   output logic [7:0]          move_count,
   output logic                data_clr,
   output logic                data_write,
   output logic [COORD_W-1:0]  write_y,
   output logic [COORD_W-1:0]  write_x,
   output logic                write_color,
   output logic [COORD_W-1:0]  logic_y,
   input  logic [BOARD_N-1:0]  logic_row,
   output logic [COORD_W-1:0]  consider_y,
   output logic [COORD_W-1:0]  consider_x,
   input  logic [WIN_W-1:0]    black_y,
   input  logic [WIN_W-1:0]    black_x,
   input  logic [WIN_W-1:0]    black_yx,
   input  logic [WIN_W-1:0]    black_xy,
   input  logic [WIN_W-1:0]    white_y,
   input  logic [WIN_W-1:0]    white_x,
   input  logic [WIN_W-1:0]    white_yx,
   input  logic [WIN_W-1:0]    white_xy
);

   localparam int                 ROW_W   = 1 << COORD_W;
   localparam logic [COORD_W-1:0] LIM     = COORD_W'(BOARD_N);
   localparam logic [7:0]         CELLS   = 8'(BOARD_N * BOARD_N);
   localparam logic [7:0]         CNT_MAX = '1;

   state_t             state, state_nx;
   logic [COORD_W-1:0] lat_y, lat_x;
   logic               lat_color;
   logic [ROW_W-1:0]   row_ext;
   logic               occupied, illegal, any_win, is_draw;
   logic [WIN_W-1:0]   win_sel [4];
   logic [3:0]         hit;

   // Zero-extend the row so an out-of-range x still indexes a defined bit.
   assign row_ext  = {{(ROW_W - BOARD_N){1'b0}}, logic_row};
   assign occupied = row_ext[lat_x];
   assign illegal  = (lat_y >= LIM) | (lat_x >= LIM) | occupied | game_over;

   assign win_sel[0] = lat_color ? white_y  : black_y;
   assign win_sel[1] = lat_color ? white_x  : black_x;
   assign win_sel[2] = lat_color ? white_yx : black_yx;
   assign win_sel[3] = lat_color ? white_xy : black_xy;

   for (genvar d = 0; d < 4; d++) begin : g_dir
      line_run_detect #(.WIN_LEN(WIN_LEN)) u_det (
         .window (win_sel[d]),
         .found  (hit[d])
      );
   end

   assign any_win = |hit;
   assign is_draw = (move_count == CELLS);

   assign write_y     = lat_y;
   assign write_x     = lat_x;
   assign write_color = lat_color;
   assign logic_y     = lat_y;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (bus.clr_req)        state_nx = S_CLEAR;
            else if (bus.req_valid) state_nx = S_CHECK;
         end
         S_CHECK:  state_nx = illegal ? S_IDLE : S_WRITE;
         S_WRITE:  state_nx = S_SETTLE;
         S_SETTLE: state_nx = S_EVAL;
         S_EVAL:   state_nx = S_IDLE;
         S_CLEAR:  state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready  = 1'b0;
      bus.rsp_valid  = 1'b0;
      bus.rsp_status = ST_OK;
      data_write     = 1'b0;
      data_clr       = 1'b0;
      case (state)
         S_IDLE:  bus.req_ready = 1'b1;
         S_CHECK: begin
            if (illegal) begin
               bus.rsp_valid  = 1'b1;
               bus.rsp_status = ST_ILLEGAL;
            end
         end
         S_WRITE: data_write = 1'b1;
         S_EVAL: begin
            bus.rsp_valid  = 1'b1;
            bus.rsp_status = any_win ? ST_WIN : (is_draw ? ST_DRAW : ST_OK);
         end
         S_CLEAR: data_clr = 1'b1;
         default: ;
      endcase
   end

   // Consider point is loaded on the CHECK->WRITE edge so it is already valid
   // during WRITE and holds its value once the move completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_y      <= '0;
         lat_x      <= '0;
         lat_color  <= 1'b0;
         consider_y <= '0;
         consider_x <= '0;
         move_count <= '0;
         game_over  <= 1'b0;
      end else begin
         if (state == S_IDLE && !bus.clr_req && bus.req_valid) begin
            lat_y     <= bus.req_y;
            lat_x     <= bus.req_x;
            lat_color <= bus.req_color;
         end
         if (state == S_CHECK && !illegal) begin
            consider_y <= lat_y;
            consider_x <= lat_x;
         end
         if (state == S_WRITE && move_count != CNT_MAX)
            move_count <= move_count + 8'd1;
         if (state == S_EVAL && (any_win || is_draw))
            game_over <= 1'b1;
         if (state == S_CLEAR) begin
            move_count <= '0;
            game_over  <= 1'b0;
         end
      end
   end

endmodule

// File: doc/move_commit_ctrl.md
# move_commit_ctrl

Sequencer between game logic and the board datapath. It accepts one move request at a time and checks that the target cell is empty. It then issues the write, drives the consider point to the new stone, evaluates the four 9-bit line windows for five-in-a-row, and returns a single status response. It also owns board clear and the move counter used for draw detection.

## Interface
Parameters:
- BOARD_N, 15: board edge length; coordinates 0..BOARD_N-1.
- WIN_LEN, 5: run length that wins.

Ports:
- clk  in  1  system clock (board datapath clock domain).
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  move request.
- req_ready  out  1  controller idle and accepting.
- req_y, req_x  in  4 each  target cell.
- req_color  in  1  0 = black, 1 = white.
- clr_req  in  1  level request to clear the board.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_status  out  2  0 OK, 1 ILLEGAL, 2 WIN, 3 DRAW.
- game_over  out  1  set by WIN/DRAW, cleared by board clear.
- move_count  out  8  stones placed since last clear.
- data_clr, data_write  out  1 each  datapath strobes, one cycle each.
- write_y, write_x  out  4 each  write address.
- write_color  out  1  write color.
- logic_y  out  4  occupancy row select.
- logic_row  in  15  occupancy of row logic_y; bit x = 1 if occupied by either color.
- consider_y, consider_x  out  4 each  window center.
- black_y/x/yx/xy  in  9 each  black line windows through the consider point.
- white_y/x/yx/xy  in  9 each  white line windows through the consider point.
  - Bit 4 is the center; off-board bits read 0.

## Operation
- States: IDLE, CHECK, WRITE, SETTLE, EVAL, CLEAR.
- IDLE:
  - req_ready = 1.
  - clr_req has priority over req_valid: go to CLEAR.
  - Otherwise, on req_valid: latch y/x/color and go to CHECK.
- CHECK:
  - logic_y = latched y; sample logic_row[x].
  - ILLEGAL if any of: y or x ≥ BOARD_N; cell occupied; game_over = 1.
  - ILLEGAL → IDLE with rsp_valid=1, status=1; no write.
  - Otherwise → WRITE.
- WRITE:
  - data_write=1 with write_y/x/color = latched values.
  - consider_y/x = latched y/x.
  - move_count += 1, saturating at 255.
- SETTLE: hold consider; the datapath windows update.
- EVAL:
  - Select the color's four windows.
  - WIN if any window contains WIN_LEN consecutive 1s; for a 9-bit window every such run covers bit 4.
  - Else DRAW if move_count == BOARD_N².
  - Else OK.
  - WIN has priority over DRAW.
  - WIN or DRAW sets game_over.
  - Assert rsp_valid with the status, then → IDLE.
- CLEAR: data_clr=1 for one cycle; move_count=0; game_over=0 → IDLE. No rsp_valid.
- consider_y/x hold their last value outside WRITE/SETTLE/EVAL.
- The request handshake is complete when req_valid & req_ready are both high; request fields are don't-care afterwards.

## Timing
- Reset values (asynchronous on rst=0):
  - State IDLE; req_ready=1.
  - rsp_valid=0, rsp_status=0, game_over=0, move_count=0.
  - All strobes 0; all address outputs 0.
- Reset mid-operation abandons the move. No write is issued after reset asserts; a write already committed stays on the board, and move_count is cleared.
- Legal move latency: accept at cycle 0; CHECK 1, WRITE 2, SETTLE 3; EVAL 4 with rsp_valid at cycle 4.
- Illegal latency: rsp_valid at cycle 1.
- Clear latency: data_clr at cycle 1.
- Earliest next accept: cycle after rsp_valid or after data_clr.
- req_ready is 0 in every non-IDLE state.
- clr_req asserted while busy is held by the requester and serviced on return to IDLE.

## Structure
- Shared package `gomoku_pkg`:
  - BOARD_N and WIN_LEN.
  - Status encodings ST_OK/ST_ILLEGAL/ST_WIN/ST_DRAW.
  - Coordinate width constant (4).
- Sub-module `line_run_detect`: combinational, 9-bit window in, WIN_LEN param; outputs 1 if a run of WIN_LEN exists. Instantiated four times on a color-muxed window set.
- FSM, latches and counter live in the top.

## Test plan
- Empty board, request (7,7) black → data_write at cycle 2 to (7,7,0); rsp status 0 at cycle 4; move_count=1.
- Repeat (7,7) white → rsp status 1 at cycle 1; no data_write.
- Five black stones along a diagonal: windows black_yx=9'b000011111 on the final move → status 2 and game_over=1. The next legal-cell request → status 1.
- Request x=15 → status 1 with no write. Four-stone window 9'b000111100 → status 0.
- Preload move_count=224 with 224 non-winning moves; the 225th non-winning move → status 3. The same move completing five → status 2.
- Assert rst low at the SETTLE cycle → all outputs at reset values next edge. After release, clr_req → one data_clr pulse, move_count=0, no rsp_valid.
